fifo_rd_burst_ctrl: RTL and testbench

Read-side sequencer for the cache's clock-domain-crossing FIFO. On a burst request from the cache refill logic it pops exactly BURST_LEN entries from the async FIFO (registered DOUT, one-cycle read latency, EMPTY flag), buffers them in a 2-entry skid buffer and streams them downstream over a valid/ready handshake. It marks the last beat and pulses completion. Sits entirely in the RD_CLK domain, between the FIFO read port and the line-fill datapath.

---
 rtl/fifo_rd_burst_ctrl_pkg.sv | 28 ++
 rtl/fifo_rd_burst_ctrl_rd_skid_buf.sv | 81 ++++++++
 rtl/fifo_rd_burst_ctrl.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_burst_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_burst_ctrl_pkg.sv
// Shared definitions for the FIFO read-side burst sequencer: state encoding,
// default widths and the pop-issue space check.
package fifo_rd_burst_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // A new pop may only be issued when the word it returns is guaranteed a
    // slot: entries held plus the word already in flight, minus the entry
    // leaving this cycle, must stay below the 2-entry buffer depth.
    function automatic logic can_issue(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       accept);
        logic [2:0] demand;
        logic [2:0] limit;
        demand = {1'b0, occ} + {2'b00, inflight};
        limit  = 3'd2 + {2'b00, accept};
        return (demand < limit);
    endfunction

endpackage

// File: rtl/fifo_rd_burst_ctrl_rd_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the downstream
// handshake. Entry 0 is always the head; a push and a pop in the same cycle
// on a full buffer both take effect and leave the occupancy unchanged.
module rd_skid_buf
    import fifo_rd_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  RD_CLK,
    input  logic                  nRST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop_s;
    logic                  push_s;

    // Next-state for the entries and occupancy from push/pop/clear.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        pop_s  = pop & (occ_q != 2'd0);
        push_s = push & ((occ_q != 2'd2) | pop_s);
        if (clear) begin
            ent0_d = '0;
            ent1_d = '0;
            occ_d  = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_d = push_data;
                    end else begin
                        ent1_d = push_data;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_d = push_data;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_data;
                    end
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge RD_CLK or negedge nRST) begin
        if (!nRST) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = ent0_q;

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst sequencer for the refill CDC FIFO. Pops exactly the
// requested number of entries, respecting the one-cycle FIFO read latency,
// and streams them downstream over valid/ready with a last-beat marker and a
// completion pulse. An abort drops buffered and in-flight data.
module fifo_rd_burst_ctrl
    import fifo_rd_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  nRST,
    input  logic                  RD_CLK,
    input  logic                  BURST_REQ,
    input  logic [LEN_WIDTH-1:0]  BURST_LEN,
    input  logic                  ABORT,
    output logic                  BUSY,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    output logic                  fifo_read,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic                  BURST_DONE
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    rd_state_e             state_q, state_d;
    logic [LEN_WIDTH-1:0]  pops_left_q, pops_left_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]            occ_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  run_s;
    logic                  out_valid_s;
    logic                  accept_s;
    logic                  fifo_read_s;
    logic                  push_s;
    logic                  clear_s;

    // Handshake, pop issue and buffer control for the current cycle.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        out_valid_s = run_s & (occ_s != 2'd0);
        accept_s    = out_valid_s & OUT_READY;
        fifo_read_s = run_s & (pops_left_q != '0) & ~FIFO_EMPTY & ~ABORT &
                      can_issue(occ_s, inflight_q, accept_s);
        // The word returned for an abort-cycle or flush-time pop is dropped.
        push_s      = run_s & inflight_q & ~ABORT;
        clear_s     = run_s & ABORT;
    end

    // Burst FSM next state and counter updates.
    always_comb begin
        state_d      = state_q;
        pops_left_d  = pops_left_q;
        beats_left_d = beats_left_q;
        inflight_d   = fifo_read_s;
        case (state_q)
            ST_IDLE: begin
                if (BURST_REQ) begin
                    if (BURST_LEN != '0) begin
                        pops_left_d  = BURST_LEN;
                        beats_left_d = BURST_LEN;
                        state_d      = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    pops_left_d  = '0;
                    beats_left_d = '0;
                    state_d      = ST_FLUSH;
                end else begin
                    if (fifo_read_s && (pops_left_q != '0)) begin
                        pops_left_d = pops_left_q - LEN_ONE;
                    end else begin
                        pops_left_d = pops_left_q;
                    end
                    if (accept_s && (beats_left_q != '0)) begin
                        beats_left_d = beats_left_q - LEN_ONE;
                    end else begin
                        beats_left_d = beats_left_q;
                    end
                    if (accept_s && (beats_left_q == LEN_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (!inflight_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                pops_left_d  = '0;
                beats_left_d = '0;
            end
        endcase
    end

    // FSM state, counters and in-flight pop flag.
    always_ff @(posedge RD_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            pops_left_q  <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pops_left_q  <= pops_left_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .RD_CLK    (RD_CLK),
        .nRST      (nRST),
        .push      (push_s),
        .push_data (FIFO_DOUT),
        .pop       (accept_s),
        .clear     (clear_s),
        .occ       (occ_s),
        .head_data (head_s)
    );

    assign fifo_read  = fifo_read_s;
    assign OUT_VALID  = out_valid_s;
    assign OUT_DATA   = head_s;
    assign OUT_LAST   = out_valid_s & (beats_left_q == LEN_ONE);
    assign BUSY       = (state_q != ST_IDLE);
    assign BURST_DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Directed bench for fifo_rd_burst_ctrl with a behavioural FIFO (registered
// DOUT, one-cycle read latency) and a beat/pop monitor.
module tb_fifo_rd_burst_ctrl;

    logic         nRST = 1'b0;
    logic         RD_CLK = 1'b0;
    logic         BURST_REQ = 1'b0;
    logic [3:0]   BURST_LEN = 4'd0;
    logic         ABORT = 1'b0;
    logic         BUSY;
    logic         fifo_empty = 1'b1;
    logic [127:0] FIFO_DOUT = 128'd0;
    logic         fifo_read;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [127:0] OUT_DATA;
    logic         OUT_LAST;
    logic         BURST_DONE;

    logic         wr_en = 1'b0;
    logic [127:0] wr_data = 128'd0;
    logic         fifo_clr = 1'b0;

    logic [127:0] fq[$];
    logic [127:0] beat_q[$];
    logic         last_q[$];
    int           pop_cnt = 0;
    int           done_cnt = 0;
    int           viol = 0;
    int           checks = 0;
    int           failures = 0;
    int           pb;
    int           bb;
    int           db;

    fifo_rd_burst_ctrl #(.DATA_WIDTH(128), .LEN_WIDTH(4)) dut (
        .nRST       (nRST),
        .RD_CLK     (RD_CLK),
        .BURST_REQ  (BURST_REQ),
        .BURST_LEN  (BURST_LEN),
        .ABORT      (ABORT),
        .BUSY       (BUSY),
        .FIFO_EMPTY (fifo_empty),
        .FIFO_DOUT  (FIFO_DOUT),
        .fifo_read  (fifo_read),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_LAST   (OUT_LAST),
        .BURST_DONE (BURST_DONE)
    );

    always #5 RD_CLK = ~RD_CLK;

    // FIFO model and monitor: record pops/beats/completions, then update FIFO.
    always @(posedge RD_CLK) begin
        logic [127:0] rd_word;
        if (fifo_read) begin
            pop_cnt++;
            if (fifo_empty) viol++;
        end
        if (OUT_VALID && OUT_READY) begin
            beat_q.push_back(OUT_DATA);
            last_q.push_back(OUT_LAST);
        end
        if (BURST_DONE) done_cnt++;
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_read && fq.size() > 0) begin
                rd_word = fq.pop_front();
                FIFO_DOUT <= rd_word;
            end
            if (wr_en) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_load(input logic [127:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge RD_CLK);
            wr_en = 1'b1;
            wr_data = base + 128'(i);
        end
        @(negedge RD_CLK);
        wr_en = 1'b0;
    endtask

    task automatic fifo_flush();
        @(negedge RD_CLK);
        fifo_clr = 1'b1;
        @(negedge RD_CLK);
        fifo_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge RD_CLK);
            n++;
        end
        chk(tag, 128'(done_cnt > base), 128'd1);
    endtask

    task automatic step();
        @(negedge RD_CLK);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge RD_CLK);
        #1;
        chk("rst_busy", 128'(BUSY), 128'd0);
        chk("rst_rd", 128'(fifo_read), 128'd0);
        chk("rst_valid", 128'(OUT_VALID), 128'd0);
        chk("rst_data", OUT_DATA, 128'd0);
        chk("rst_last", 128'(OUT_LAST), 128'd0);
        chk("rst_done", 128'(BURST_DONE), 128'd0);
        @(negedge RD_CLK);
        nRST = 1'b1;

        // Test 1: preloaded 4-beat burst at full rate
        fifo_load(128'hA0, 4);
        pb = pop_cnt; bb = beat_q.size(); db = done_cnt;
        OUT_READY = 1'b1; BURST_REQ = 1'b1; BURST_LEN = 4'd4;
        #1;
        chk("t1_idle_busy", 128'(BUSY), 128'd0);
        chk("t1_idle_rd", 128'(fifo_read), 128'd0);
        @(negedge RD_CLK); BURST_REQ = 1'b0; #1;
        chk("t1_busy", 128'(BUSY), 128'd1);
        chk("t1_rd_c1", 128'(fifo_read), 128'd1);
        step();
        chk("t1_rd_c2", 128'(fifo_read), 128'd1);
        chk("t1_valid_c2", 128'(OUT_VALID), 128'd0);
        step();
        chk("t1_rd_c3", 128'(fifo_read), 128'd1);
        chk("t1_valid_c3", 128'(OUT_VALID), 128'd1);
        chk("t1_data_c3", OUT_DATA, 128'hA0);
        step();
        chk("t1_rd_c4", 128'(fifo_read), 128'd1);
        chk("t1_data_c4", OUT_DATA, 128'hA1);
        step();
        chk("t1_rd_c5", 128'(fifo_read), 128'd0);
        chk("t1_data_c5", OUT_DATA, 128'hA2);
        chk("t1_last_c5", 128'(OUT_LAST), 128'd0);
        step();
        chk("t1_data_c6", OUT_DATA, 128'hA3);
        chk("t1_last_c6", 128'(OUT_LAST), 128'd1);
        step();
        chk("t1_done_c7", 128'(BURST_DONE), 128'd1);
        chk("t1_valid_c7", 128'(OUT_VALID), 128'd0);
        step();
        chk("t1_done_c8", 128'(BURST_DONE), 128'd0);
        chk("t1_busy_c8", 128'(BUSY), 128'd0);
        chk("t1_pops", 128'(pop_cnt - pb), 128'd4);
        chk("t1_ndone", 128'(done_cnt - db), 128'd1);

        // Test 2: 3-beat burst with downstream stalled for 5 cycles
        fifo_load(128'hB0, 3);
        pb = pop_cnt; bb = beat_q.size();
        OUT_READY = 1'b0; BURST_REQ = 1'b1; BURST_LEN = 4'd3;
        @(negedge RD_CLK); BURST_REQ = 1'b0;
        @(negedge RD_CLK);
        step();
        chk("t2_rd_stall3", 128'(fifo_read), 128'd0);
        step();
        chk("t2_rd_stall4", 128'(fifo_read), 128'd0);
        chk("t2_pops_stall", 128'(pop_cnt - pb), 128'd2);
        chk("t2_head_stall", OUT_DATA, 128'hB0);
        @(negedge RD_CLK); OUT_READY = 1'b1;
        wait_done("t2_timeout", 40);
        chk("t2_pops", 128'(pop_cnt - pb), 128'd3);
        chk("t2_nbeats", 128'(beat_q.size() - bb), 128'd3);
        chk("t2_b0", beat_q[bb], 128'hB0);
        chk("t2_b1", beat_q[bb+1], 128'hB1);
        chk("t2_b2", beat_q[bb+2], 128'hB2);
        chk("t2_last1", 128'(last_q[bb+1]), 128'd0);
        chk("t2_last2", 128'(last_q[bb+2]), 128'd1);

        // Test 3: FIFO starts empty, one entry every 4 cycles
        fifo_flush();
        pb = pop_cnt; bb = beat_q.size();
        BURST_REQ = 1'b1; BURST_LEN = 4'd2;
        @(negedge RD_CLK); BURST_REQ = 1'b0; #1;
        chk("t3_rd_empty", 128'(fifo_read), 128'd0);
        for (int i = 0; i < 2; i++) begin
            repeat (3) @(negedge RD_CLK);
            wr_en = 1'b1; wr_data = 128'hC0 + 128'(i);
            @(negedge RD_CLK); wr_en = 1'b0;
        end
        wait_done("t3_timeout", 40);
        chk("t3_pops", 128'(pop_cnt - pb), 128'd2);
        chk("t3_nbeats", 128'(beat_q.size() - bb), 128'd2);
        chk("t3_b0", beat_q[bb], 128'hC0);
        chk("t3_b1", beat_q[bb+1], 128'hC1);
        chk("t3_viol", 128'(viol), 128'd0);

        // Test 4: zero-length burst
        pb = pop_cnt; bb = beat_q.size();
        BURST_REQ = 1'b1; BURST_LEN = 4'd0;
        @(negedge RD_CLK); BURST_REQ = 1'b0; #1;
        chk("t4_done", 128'(BURST_DONE), 128'd1);
        chk("t4_rd", 128'(fifo_read), 128'd0);
        chk("t4_valid", 128'(OUT_VALID), 128'd0);
        step();
        chk("t4_done_off", 128'(BURST_DONE), 128'd0);
        chk("t4_busy_off", 128'(BUSY), 128'd0);
        chk("t4_pops", 128'(pop_cnt - pb), 128'd0);
        chk("t4_beats", 128'(beat_q.size() - bb), 128'd0);

        // Test 5: abort after 3 accepted beats, then a fresh burst
        fifo_load(128'hD0, 8);
        pb = pop_cnt; bb = beat_q.size(); db = done_cnt;
        OUT_READY = 1'b1; BURST_REQ = 1'b1; BURST_LEN = 4'd8;
        @(negedge RD_CLK); BURST_REQ = 1'b0;
        repeat (5) @(negedge RD_CLK);
        OUT_READY = 1'b0; ABORT = 1'b1; #1;
        chk("t5_rd_abort", 128'(fifo_read), 128'd0);
        chk("t5_beats3", 128'(beat_q.size() - bb), 128'd3);
        @(negedge RD_CLK); ABORT = 1'b0; #1;
        chk("t5_valid_flush", 128'(OUT_VALID), 128'd0);
        chk("t5_done_flush", 128'(BURST_DONE), 128'd0);
        step();
        chk("t5_idle", 128'(BUSY), 128'd0);
        chk("t5_pops", 128'(pop_cnt - pb), 128'd5);
        OUT_READY = 1'b1; BURST_REQ = 1'b1; BURST_LEN = 4'd1;
        @(negedge RD_CLK); BURST_REQ = 1'b0;
        wait_done("t5_timeout", 20);
        chk("t5_ndone", 128'(done_cnt - db), 128'd1);
        chk("t5_new_beat", beat_q[bb+3], 128'hD5);
        chk("t5_new_last", 128'(last_q[bb+3]), 128'd1);

        // Test 6: reset mid-burst with the buffer full
        fifo_flush();
        fifo_load(128'hE0, 4);
        OUT_READY = 1'b0; BURST_REQ = 1'b1; BURST_LEN = 4'd4;
        @(negedge RD_CLK); BURST_REQ = 1'b0;
        repeat (2) @(negedge RD_CLK);
        step();
        chk("t6_full_valid", 128'(OUT_VALID), 128'd1);
        chk("t6_full_head", OUT_DATA, 128'hE0);
        chk("t6_full_rd", 128'(fifo_read), 128'd0);
        nRST = 1'b0; #1;
        chk("t6_rst_busy", 128'(BUSY), 128'd0);
        chk("t6_rst_valid", 128'(OUT_VALID), 128'd0);
        chk("t6_rst_data", OUT_DATA, 128'd0);
        chk("t6_rst_last", 128'(OUT_LAST), 128'd0);
        chk("t6_rst_done", 128'(BURST_DONE), 128'd0);
        chk("t6_rst_rd", 128'(fifo_read), 128'd0);
        @(negedge RD_CLK); nRST = 1'b1;
        fifo_flush();
        fifo_load(128'hF0, 1);
        bb = beat_q.size();
        OUT_READY = 1'b1; BURST_REQ = 1'b1; BURST_LEN = 4'd1;
        @(negedge RD_CLK); BURST_REQ = 1'b0;
        wait_done("t6_timeout", 20);
        chk("t6_nbeats", 128'(beat_q.size() - bb), 128'd1);
        chk("t6_beat", beat_q[bb], 128'hF0);
        chk("t6_last", 128'(last_q[bb]), 128'd1);
        chk("final_viol", 128'(viol), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
